booth_ctrl_fsm: RTL

// - Sequencing FSM for the Booth radix-2 datapath mult_with_no_fsm (A = multiplicand, B = multiplier held in Q).
// - Drives load_A/load_B/load_add/add_sub/shift_HQ_LQ_Q_1 and reads Q_LSB = {Q0, Q_-1}.
// - Runs exactly N Booth iterations per start. Reports completion with a one-cycle done pulse.
// - Sits beside the datapath inside the multiplier top level. Y is taken directly from the datapath when done=1.

---
 rtl/booth_pkg.sv | 11 +
 rtl/booth_iter_cnt.sv | 34 +++
 rtl/booth_ctrl_fsm.sv | 88 ++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth radix-2 multiplier control path.
package booth_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, EVAL, ADD, SHIFT, DONE} booth_state_t;

   localparam logic ADD_OP = 1'b1;
   localparam logic SUB_OP = 1'b0;

   localparam int BOOTH_N_DEFAULT = 8;

endpackage

// File: rtl/booth_iter_cnt.sv
// Booth iteration counter: cleared on load, stepped once per shift, flags the final iteration.
module booth_iter_cnt #(
   parameter int N     = 8,
   parameter int CNT_W = $clog2(N)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic last
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last = (cnt_q == CNT_W'(N - 1));

endmodule

// File: rtl/booth_ctrl_fsm.sv
// Sequencing FSM for the Booth radix-2 datapath: load, then N x (evaluate, optional add/sub, shift), then done.
module booth_ctrl_fsm
   import booth_pkg::*;
#(
   parameter int N     = BOOTH_N_DEFAULT,
   parameter int CNT_W = $clog2(N)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       ready,
   output logic       busy,
   output logic       done,
   input  logic [1:0] Q_LSB,
   output logic       load_A,
   output logic       load_B,
   output logic       load_add,
   output logic       add_sub,
   output logic       shift_HQ_LQ_Q_1
);

   booth_state_t state_q, state_d;
   logic         add_sub_q, add_sub_d;
   logic         cnt_clr, cnt_inc, cnt_last;

   // The counter only steps on non-final shifts, so it never wraps past N-1.
   assign cnt_clr = (state_q == LOAD);
   assign cnt_inc = (state_q == SHIFT) && !cnt_last;

   booth_iter_cnt #(
      .N     (N),
      .CNT_W (CNT_W)
   ) u_iter_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .inc  (cnt_inc),
      .last (cnt_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         add_sub_q <= SUB_OP;
      end else begin
         state_q   <= state_d;
         add_sub_q <= add_sub_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      add_sub_d = add_sub_q;
      case (state_q)
         IDLE:    if (start) state_d = LOAD;
         LOAD:    state_d = EVAL;
         EVAL: begin
            case (Q_LSB)
               2'b01: begin
                  add_sub_d = ADD_OP;
                  state_d   = ADD;
               end
               2'b10: begin
                  add_sub_d = SUB_OP;
                  state_d   = ADD;
               end
               default: state_d = SHIFT;
            endcase
         end
         ADD:     state_d = SHIFT;
         SHIFT:   state_d = cnt_last ? DONE : EVAL;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready            = (state_q == IDLE);
      busy             = (state_q != IDLE);
      done             = (state_q == DONE);
      load_A           = (state_q == LOAD);
      load_B           = (state_q == LOAD);
      load_add         = (state_q == ADD);
      shift_HQ_LQ_Q_1  = (state_q == SHIFT);
      add_sub          = add_sub_q;
   end

endmodule
